// File: rtl/board_reset_sequencer.sv
// -----------------------------------------------------------------------------
// board_reset_sequencer
//
// Power-up sequencer for the PL side of the board. It holds the si5338
// configurator in reset and then waits for its done/error result. After the
// clock has settled it releases the block design's sys_rst, then waits for DDR3
// calibration before it reports ready. Each phase has a timeout, and failed
// phases are retried until the retry budget runs out.
//
// Optional build macro: RST_SEQ_RECOVER_EN
//   defined   : losing clk_cfg_done or ddr_calib_done in READY takes the retry path
//   undefined : losing either input in READY goes straight to FAIL
//
// Ports
//   i_clk              50 MHz board clock, sole clock
//   i_reset            synchronous, active-high reset
//   i_clk_cfg_done     si5338 configuration complete (level)
//   i_clk_cfg_error    si5338 I2C error (level)
//   i_ddr_calib_done   DDR3 init_calib_complete, already synchronous to i_clk
//   o_clk_cfg_reset    active-high reset to the si5338 configurator
//   o_pl_sys_rst_n     block-design sys_rst, low holds reset
//   o_ready            sequence complete
//   o_fail             retry budget exhausted
//   o_state            current state code
//   o_retry_cnt        retries consumed
// -----------------------------------------------------------------------------
module board_reset_sequencer #(
   parameter int unsigned RST_HOLD      = 16,
   parameter int unsigned CFG_TIMEOUT   = 5000000,
   parameter int unsigned SETTLE_CYCLES = 500000,
   parameter int unsigned CAL_TIMEOUT   = 25000000,
   parameter int unsigned MAX_RETRY     = 3,
   parameter int unsigned TIMER_W       = 32,
   parameter int unsigned RETRY_W       = 4
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_clk_cfg_done,
   input  logic               i_clk_cfg_error,
   input  logic               i_ddr_calib_done,
   output logic               o_clk_cfg_reset,
   output logic               o_pl_sys_rst_n,
   output logic               o_ready,
   output logic               o_fail,
   output logic [2:0]         o_state,
   output logic [RETRY_W-1:0] o_retry_cnt
);

   typedef enum logic [2:0] {
      StReset   = 3'd0,
      StClkCfg  = 3'd1,
      StSettle  = 3'd2,
      StDdrWait = 3'd3,
      StReady   = 3'd4,
      StFail    = 3'd5
   } state_e;

   // A phase expires in the cycle where the timer reads limit-1.
   localparam logic [TIMER_W-1:0] L_RST_LAST = TIMER_W'(RST_HOLD - 1);
   localparam logic [TIMER_W-1:0] L_CFG_LAST = TIMER_W'(CFG_TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] L_SET_LAST = TIMER_W'(SETTLE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] L_CAL_LAST = TIMER_W'(CAL_TIMEOUT - 1);
   localparam logic [RETRY_W-1:0] L_MAX_RETRY = RETRY_W'(MAX_RETRY);

   state_e               r_state;
   logic [TIMER_W-1:0]   r_timer;
   logic [RETRY_W-1:0]   r_retry_cnt;
   logic                 r_clk_cfg_reset;
   logic                 r_pl_sys_rst_n;
   logic                 r_ready;
   logic                 r_fail;

   state_e               w_next;
   logic                 w_retry;
   logic                 w_retry_inc;

   // Next-state selection. Failing phases raise w_retry; the retry budget
   // then decides between another attempt and FAIL.
   always_comb begin
      w_next      = r_state;
      w_retry     = 1'b0;
      w_retry_inc = 1'b0;
      case (r_state)
         StReset: begin
            if (r_timer == L_RST_LAST) w_next = StClkCfg;
         end
         StClkCfg: begin
            // done wins over error and timeout in the same cycle
            if (i_clk_cfg_done) w_next = StSettle;
            else if (i_clk_cfg_error || (r_timer == L_CFG_LAST)) w_retry = 1'b1;
         end
         StSettle: begin
            if (!i_clk_cfg_done) w_retry = 1'b1;
            else if (r_timer == L_SET_LAST) w_next = StDdrWait;
         end
         StDdrWait: begin
            if (i_ddr_calib_done) w_next = StReady;
            else if (r_timer == L_CAL_LAST) w_retry = 1'b1;
         end
         StReady: begin
            if (!i_clk_cfg_done || !i_ddr_calib_done) begin
`ifdef RST_SEQ_RECOVER_EN
               w_retry = 1'b1;
`else
               w_next = StFail;
`endif
            end
         end
         StFail: begin
            w_next = StFail;
         end
         default: begin
            w_next = StReset;
         end
      endcase

      if (w_retry) begin
         if (r_retry_cnt == L_MAX_RETRY) begin
            w_next = StFail;
         end else begin
            w_next      = StReset;
            w_retry_inc = 1'b1;
         end
      end
   end

   // State, timer, retry count and Moore outputs all load on the same edge;
   // the outputs are decoded from the state being entered.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state         <= StReset;
         r_timer         <= '0;
         r_retry_cnt     <= '0;
         r_clk_cfg_reset <= 1'b1;
         r_pl_sys_rst_n  <= 1'b0;
         r_ready         <= 1'b0;
         r_fail          <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state) r_timer <= '0;
         else                   r_timer <= r_timer + TIMER_W'(1);
         if (w_retry_inc) r_retry_cnt <= r_retry_cnt + RETRY_W'(1);
         r_clk_cfg_reset <= (w_next == StReset) || (w_next == StFail);
         r_pl_sys_rst_n  <= (w_next == StDdrWait) || (w_next == StReady);
         r_ready         <= (w_next == StReady);
         r_fail          <= (w_next == StFail);
      end
   end

   assign o_state         = r_state;
   assign o_retry_cnt     = r_retry_cnt;
   assign o_clk_cfg_reset = r_clk_cfg_reset;
   assign o_pl_sys_rst_n  = r_pl_sys_rst_n;
   assign o_ready         = r_ready;
   assign o_fail          = r_fail;

endmodule

// File: tb/tb_board_reset_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for board_reset_sequencer. Two instances share the inputs: one with
// MAX_RETRY=2, one with MAX_RETRY=0. A phase/age/retry model predicts every
// output on every cycle. Directed scenarios add hand-computed checkpoints.
// -----------------------------------------------------------------------------
module tb_board_reset_sequencer;

   localparam int unsigned RST_HOLD      = 4;
   localparam int unsigned CFG_TIMEOUT   = 100;
   localparam int unsigned SETTLE_CYCLES = 10;
   localparam int unsigned CAL_TIMEOUT   = 200;
   localparam int unsigned RETRY_W       = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic done = 1'b0;
   logic err = 1'b0;
   logic calib = 1'b0;

   logic               a_cfg_rst, a_pl, a_rdy, a_fail;
   logic [2:0]         a_state;
   logic [RETRY_W-1:0] a_rc;
   logic               b_cfg_rst, b_pl, b_rdy, b_fail;
   logic [2:0]         b_state;
   logic [RETRY_W-1:0] b_rc;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   // Model: phase code, cycles spent in the phase, retries used, per instance.
   int m_ph[2];
   int m_age[2];
   int m_rc[2];
   int m_max[2];

   always #5 clk = ~clk;

   board_reset_sequencer #(
      .RST_HOLD(RST_HOLD), .CFG_TIMEOUT(CFG_TIMEOUT), .SETTLE_CYCLES(SETTLE_CYCLES),
      .CAL_TIMEOUT(CAL_TIMEOUT), .MAX_RETRY(2), .TIMER_W(32), .RETRY_W(RETRY_W)
   ) u_dut_a (
      .i_clk(clk), .i_reset(rst), .i_clk_cfg_done(done), .i_clk_cfg_error(err),
      .i_ddr_calib_done(calib), .o_clk_cfg_reset(a_cfg_rst), .o_pl_sys_rst_n(a_pl),
      .o_ready(a_rdy), .o_fail(a_fail), .o_state(a_state), .o_retry_cnt(a_rc)
   );

   board_reset_sequencer #(
      .RST_HOLD(RST_HOLD), .CFG_TIMEOUT(CFG_TIMEOUT), .SETTLE_CYCLES(SETTLE_CYCLES),
      .CAL_TIMEOUT(CAL_TIMEOUT), .MAX_RETRY(0), .TIMER_W(32), .RETRY_W(RETRY_W)
   ) u_dut_b (
      .i_clk(clk), .i_reset(rst), .i_clk_cfg_done(done), .i_clk_cfg_error(err),
      .i_ddr_calib_done(calib), .o_clk_cfg_reset(b_cfg_rst), .o_pl_sys_rst_n(b_pl),
      .o_ready(b_rdy), .o_fail(b_fail), .o_state(b_state), .o_retry_cnt(b_rc)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at cyc %0d: got %0d want %0d", name, cyc, act, exp);
      end
   endtask

   // Advance one phase of the model by one clock using the inputs at this edge.
   task automatic model_step(input int k);
      int  nph;
      bit  fault;
      if (rst) begin
         m_ph[k]  = 0;
         m_age[k] = 0;
         m_rc[k]  = 0;
         return;
      end
      nph   = m_ph[k];
      fault = 1'b0;
      case (m_ph[k])
         0: if (m_age[k] == RST_HOLD - 1) nph = 1;
         1: begin
            if (done) nph = 2;
            else if (err || m_age[k] == CFG_TIMEOUT - 1) fault = 1'b1;
         end
         2: begin
            if (!done) fault = 1'b1;
            else if (m_age[k] == SETTLE_CYCLES - 1) nph = 3;
         end
         3: begin
            if (calib) nph = 4;
            else if (m_age[k] == CAL_TIMEOUT - 1) fault = 1'b1;
         end
         4: begin
            if (!done || !calib) begin
`ifdef RST_SEQ_RECOVER_EN
               fault = 1'b1;
`else
               nph = 5;
`endif
            end
         end
         default: nph = m_ph[k];
      endcase
      if (fault) begin
         if (m_rc[k] >= m_max[k]) begin
            nph = 5;
         end else begin
            m_rc[k]++;
            nph = 0;
         end
      end
      m_age[k] = (nph != m_ph[k]) ? 0 : m_age[k] + 1;
      m_ph[k]  = nph;
   endtask

   task automatic compare_inst(input int k, input string p, input int st, input int cr,
                               input int pl, input int rd, input int fl, input int rc);
      int ph;
      ph = m_ph[k];
      chk({p, ".state"}, st, ph);
      chk({p, ".clk_cfg_reset"}, cr, int'(ph == 0 || ph == 5));
      chk({p, ".pl_sys_rst_n"}, pl, int'(ph == 3 || ph == 4));
      chk({p, ".ready"}, rd, int'(ph == 4));
      chk({p, ".fail"}, fl, int'(ph == 5));
      chk({p, ".retry_cnt"}, rc, m_rc[k]);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      cyc++;
      compare_inst(0, "a", int'(a_state), int'(a_cfg_rst), int'(a_pl), int'(a_rdy),
                   int'(a_fail), int'(a_rc));
      compare_inst(1, "b", int'(b_state), int'(b_cfg_rst), int'(b_pl), int'(b_rdy),
                   int'(b_fail), int'(b_rc));
   endtask

   task automatic run_to(input int n);
      while (cyc < n) tick();
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      done  = 1'b0;
      err   = 1'b0;
      calib = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      cyc = 0;
   endtask

   initial begin
      m_max[0] = 2;
      m_max[1] = 0;

      // Nominal bring-up, then loss in READY
      do_reset();
      chk("rst.state", int'(a_state), 0);
      chk("rst.clk_cfg_reset", int'(a_cfg_rst), 1);
      chk("rst.pl_sys_rst_n", int'(a_pl), 0);
      chk("rst.retry_cnt", int'(a_rc), 0);
      chk("rst.model_ph", m_ph[0], 0);
      run_to(3);  chk("nom.hold_state", int'(a_state), 0);
      run_to(4);  chk("nom.cfg_state", int'(a_state), 1);
      chk("nom.cfg_rst_low", int'(a_cfg_rst), 0);
      run_to(19); done = 1'b1;
      run_to(20); chk("nom.settle", int'(a_state), 2);
      run_to(29); chk("nom.pl_still_low", int'(a_pl), 0);
      run_to(30); chk("nom.ddr", int'(a_state), 3);
      chk("nom.pl_high", int'(a_pl), 1);
      chk("nom.model_ddr", m_ph[0], 3);
      run_to(59); calib = 1'b1;
      run_to(60); chk("nom.ready", int'(a_rdy), 1);
      chk("nom.state4", int'(a_state), 4);
      chk("nom.rc0", int'(a_rc), 0);
      run_to(70); chk("nom.ready_held", int'(a_rdy), 1);
      calib = 1'b0;
      run_to(71); calib = 1'b1;
`ifdef RST_SEQ_RECOVER_EN
      chk("loss.state", int'(a_state), 0);
      chk("loss.rc", int'(a_rc), 1);
      chk("loss.ready", int'(a_rdy), 0);
`else
      chk("loss.state", int'(a_state), 5);
      chk("loss.fail", int'(a_fail), 1);
      chk("loss.ready", int'(a_rdy), 0);
`endif
      chk("loss.b_state", int'(b_state), 5);
      run_to(80);

      // Configuration timeout
      do_reset();
      run_to(103); chk("cto.cfg", int'(a_state), 1);
      run_to(104); chk("cto.rc1", int'(a_rc), 1);
      chk("cto.reset", int'(a_state), 0);
      chk("cto.b_fail", int'(b_fail), 1);
      chk("cto.b_rc", int'(b_rc), 0);
      run_to(208); chk("cto.rc2", int'(a_rc), 2);
      run_to(311); chk("cto.cfg3", int'(a_state), 1);
      run_to(312); chk("cto.fail_state", int'(a_state), 5);
      chk("cto.fail", int'(a_fail), 1);
      chk("cto.rc_final", int'(a_rc), 2);
      chk("cto.cfg_rst", int'(a_cfg_rst), 1);
      chk("cto.model_rc", m_rc[0], 2);
      run_to(330); chk("cto.terminal", int'(a_state), 5);

      // Error, then done and error together
      do_reset();
      run_to(9);  err = 1'b1;
      run_to(10); err = 1'b0;
      chk("err.rc", int'(a_rc), 1);
      chk("err.state", int'(a_state), 0);
      run_to(14); chk("err.cfg", int'(a_state), 1);
      run_to(15); done = 1'b1; err = 1'b1;
      run_to(16); err = 1'b0;
      chk("err.done_wins", int'(a_state), 2);
      run_to(30);

      // Calibration timeout, then success
      do_reset();
      run_to(4);   done = 1'b1;
      run_to(15);  chk("cal.ddr", int'(a_state), 3);
      run_to(214); chk("cal.pl_high", int'(a_pl), 1);
      run_to(215); chk("cal.pl_low", int'(a_pl), 0);
      chk("cal.rc", int'(a_rc), 1);
      chk("cal.state", int'(a_state), 0);
      run_to(231); calib = 1'b1;
      run_to(232); chk("cal.ready", int'(a_state), 4);
      chk("cal.rc_kept", int'(a_rc), 1);
      run_to(240);

      // Settle glitch, then reset mid DDR_WAIT
      do_reset();
      run_to(4);  done = 1'b1;
      run_to(9);  done = 1'b0;
      run_to(10); done = 1'b1;
      chk("glitch.state", int'(a_state), 0);
      chk("glitch.rc", int'(a_rc), 1);
      chk("glitch.pl", int'(a_pl), 0);
      run_to(30); chk("mid.ddr", int'(a_state), 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid.state", int'(a_state), 0);
      chk("mid.rc", int'(a_rc), 0);
      chk("mid.pl", int'(a_pl), 0);
      chk("mid.cfg_rst", int'(a_cfg_rst), 1);

      // Randomised traffic against the model
      do_reset();
      done = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0) done = ~done;
         if ($urandom_range(0, 29) == 0) calib = ~calib;
         err = ($urandom_range(0, 59) == 0);
         rst = ($urandom_range(0, 599) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/board_reset_sequencer.md
Name: board_reset_sequencer

Overview:
- Power-up sequencer for the PL side of the board.
- Drives the si5338 clock-generator configurator's active-high reset and waits for its done/error result.
- After clock settle, releases the processing-system block's active-low sys_rst, then waits for PL DDR3 calibration before declaring the board ready.
- Times out and retries each phase, with a bounded retry budget; sits in the top level between si5338 and the block design.

Parameters:
RST_HOLD, 16, cycles clk_cfg_reset is held high per attempt
CFG_TIMEOUT, 5000000, max cycles waiting for clk_cfg_done (100 ms at 50 MHz)
SETTLE_CYCLES, 500000, cycles clk_cfg_done must stay high before releasing pl_sys_rst_n
CAL_TIMEOUT, 25000000, max cycles waiting for ddr_calib_done after release
MAX_RETRY, 3, retries allowed before FAIL
TIMER_W, 32, timer width; must hold the largest timeout
RETRY_W, 4, retry counter width

Ports:
clk  input  1  50 MHz board clock (sys_clk); sole clock
reset  input  1  synchronous, active-high
clk_cfg_done  input  1  si5338 configuration complete (level)
clk_cfg_error  input  1  si5338 I2C error (level)
ddr_calib_done  input  1  PL DDR3 init_calib_complete, pre-synchronised to clk
clk_cfg_reset  output  1  active-high reset to si5338 configurator
pl_sys_rst_n  output  1  block-design sys_rst; low holds reset
ready  output  1  sequence complete
fail  output  1  retry budget exhausted
state  output  3  current state code
retry_cnt  output  RETRY_W  retries consumed

Behaviour:
- One clock, one reset: synchronous, active-high. All outputs are registered Moore decodes of the state register and change on the same edge as state.
- Reset values: state=0, clk_cfg_reset=1, pl_sys_rst_n=0, ready=0, fail=0, retry_cnt=0, timer=0.
- State codes: RESET=0, CLK_CFG=1, SETTLE=2, DDR_WAIT=3, READY=4, FAIL=5. Codes 6 and 7 go to RESET on the next edge.
- Timer rules: timer clears on every state change and otherwise increments by 1 each cycle. A phase "expires" when timer == limit-1 in that cycle.
- RESET: clk_cfg_reset=1, pl_sys_rst_n=0. Leaves for CLK_CFG after RST_HOLD cycles.
- CLK_CFG: clk_cfg_reset=0.
  - clk_cfg_done=1 -> SETTLE. Done has priority over error and timeout in the same cycle.
  - Otherwise, clk_cfg_error=1 or CFG_TIMEOUT expiry -> retry path.
- SETTLE: clk_cfg_done=0 at any cycle -> retry path. After SETTLE_CYCLES -> DDR_WAIT.
- DDR_WAIT: pl_sys_rst_n=1.
  - ddr_calib_done=1 -> READY.
  - CAL_TIMEOUT expiry -> retry path. pl_sys_rst_n returns to 0 on that same edge.
- READY: ready=1, pl_sys_rst_n=1, clk_cfg_reset=0. Loss handling is set by the optional feature.
- Retry path:
  - retry_cnt == MAX_RETRY -> FAIL; retry_cnt is unchanged.
  - Otherwise retry_cnt += 1 and go to RESET.
- FAIL: fail=1, clk_cfg_reset=1, pl_sys_rst_n=0. Terminal; only reset exits.
- retry_cnt is cleared only by reset. It is not cleared on reaching READY.
- reset asserted in any state, mid-count included, returns all registers to reset values on the next edge.
- MAX_RETRY=0: the first failure goes directly to FAIL.

Optional Feature:
- Macro: RST_SEQ_RECOVER_EN.
- Defined: in READY, clk_cfg_done=0 or ddr_calib_done=0 for one cycle triggers the retry path.
  - Budget left: go to RESET. ready and pl_sys_rst_n drop on that edge.
  - Budget exhausted: go to FAIL.
- Undefined: in READY, either loss goes directly to FAIL. ready=0 and fail=1 on that edge, with no retry.
- In both builds, READY is held while both inputs stay high.

Test Plan:
(Bench params: RST_HOLD=4, CFG_TIMEOUT=100, SETTLE_CYCLES=10, CAL_TIMEOUT=200, MAX_RETRY=2.)
- Nominal: after reset, raise clk_cfg_done at cycle 20 and ddr_calib_done 30 cycles after pl_sys_rst_n rises.
  -> clk_cfg_reset low at cycle 4; state 1->2->3->4; pl_sys_rst_n rises 10 cycles after done; ready=1; retry_cnt=0.
- Config timeout: never assert clk_cfg_done.
  -> three RESET/CLK_CFG cycles each 4+100 cycles long; retry_cnt 1 then 2; then FAIL (state=5, fail=1, retry_cnt=2, clk_cfg_reset=1).
- Error vs done: pulse clk_cfg_error at cycle 10 -> retry_cnt=1, state=0. On the next attempt, assert done and error in the same cycle -> SETTLE.
- Calibration timeout then success: first DDR_WAIT gets no calib -> at expiry pl_sys_rst_n=0 and retry_cnt=1. Second attempt asserts calib -> READY with retry_cnt=1.
- Settle glitch: drop clk_cfg_done for 1 cycle at SETTLE cycle 5 -> retry path; pl_sys_rst_n never rose.
- Loss in READY: drop ddr_calib_done for 1 cycle.
  -> With RST_SEQ_RECOVER_EN: state=0, retry_cnt+1, ready=0 on the next edge.
  -> Without it: state=5, fail=1.
  -> Separately, assert reset mid-DDR_WAIT -> reset values next edge.
